// File: rtl/cpu_pkg.sv
// Shared encodings for the RISC controller: instruction fields, FSM states, select one-hots
// and the packed control word that the output decoder produces.
package cpu_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;

    localparam logic [4:0] INS_MOVI = {OPC_MOV, OP_MOVI};
    localparam logic [4:0] INS_MOVR = {OPC_MOV, OP_MOVR};
    localparam logic [4:0] INS_ADD  = {OPC_ALU, OP_ADD};
    localparam logic [4:0] INS_CMP  = {OPC_ALU, OP_CMP};
    localparam logic [4:0] INS_AND  = {OPC_ALU, OP_AND};
    localparam logic [4:0] INS_MVN  = {OPC_ALU, OP_MVN};

    localparam logic [2:0] S_WAIT      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_WRITE_IMM = 3'd2;
    localparam logic [2:0] S_GET_A     = 3'd3;
    localparam logic [2:0] S_GET_B     = 3'd4;
    localparam logic [2:0] S_ALU       = 3'd5;
    localparam logic [2:0] S_WRITE_REG = 3'd6;
    localparam logic [2:0] S_ERR       = 3'd7;

    typedef enum logic [2:0] {
        ST_WAIT      = S_WAIT,
        ST_DECODE    = S_DECODE,
        ST_WRITE_IMM = S_WRITE_IMM,
        ST_GET_A     = S_GET_A,
        ST_GET_B     = S_GET_B,
        ST_ALU       = S_ALU,
        ST_WRITE_REG = S_WRITE_REG,
        ST_ERR       = S_ERR
    } state_e;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RM   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RN   = 3'b100;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    typedef struct packed {
        logic       w;
        logic       err;
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [3:0] vsel;
        logic       write;
    } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_outdec.sv
// Moore output decoder: maps the registered state (and latched instruction) to the control word.
// The ERR state output is only decoded when CPU_CTRL_TRAP_EN is defined.
module cpu_ctrl_outdec
    import cpu_pkg::*;
(
    input  state_e     i_state,
    input  logic [4:0] i_instr,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_WAIT: o_ctrl.w = 1'b1;
            ST_WRITE_IMM: begin
                o_ctrl.nsel  = NSEL_RN;
                o_ctrl.vsel  = VSEL_IMM8;
                o_ctrl.write = 1'b1;
            end
            ST_GET_A: begin
                o_ctrl.nsel  = NSEL_RN;
                o_ctrl.loada = 1'b1;
            end
            ST_GET_B: begin
                o_ctrl.nsel  = NSEL_RM;
                o_ctrl.loadb = 1'b1;
            end
            ST_ALU: begin
                // CMP only updates the status flags; everything else captures the result in C
                o_ctrl.asel  = (i_instr == INS_MOVR);
                o_ctrl.loads = (i_instr == INS_CMP);
                o_ctrl.loadc = (i_instr != INS_CMP);
            end
            ST_WRITE_REG: begin
                o_ctrl.nsel  = NSEL_RD;
                o_ctrl.vsel  = VSEL_C;
                o_ctrl.write = 1'b1;
            end
`ifdef CPU_CTRL_TRAP_EN
            ST_ERR: o_ctrl.err = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle instruction sequencer for the RISC datapath: one instruction per start pulse.
// Define CPU_CTRL_TRAP_EN to trap illegal encodings in a sticky ERR state (else they are no-ops).
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [3:0] vsel,
    output logic       write,
    output logic       err
);

    state_e     r_state;
    state_e     w_next;
    logic [4:0] r_instr;
    ctrl_t      w_ctrl;

    // Instruction is captured once on leaving WAIT so later opcode changes cannot redirect it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT;
            r_instr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_WAIT && s) begin
                r_instr <= {opcode, op};
            end
        end
    end

    always_comb begin
        w_next = ST_WAIT;
        case (r_state)
            ST_WAIT: w_next = s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                case (r_instr)
                    INS_MOVI:                   w_next = ST_WRITE_IMM;
                    INS_ADD, INS_CMP, INS_AND:  w_next = ST_GET_A;
                    INS_MOVR, INS_MVN:          w_next = ST_GET_B;
`ifdef CPU_CTRL_TRAP_EN
                    default:                    w_next = ST_ERR;
`else
                    default:                    w_next = ST_WAIT;
`endif
                endcase
            end
            ST_WRITE_IMM: w_next = ST_WAIT;
            ST_GET_A:     w_next = ST_GET_B;
            ST_GET_B:     w_next = ST_ALU;
            ST_ALU:       w_next = (r_instr == INS_CMP) ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: w_next = ST_WAIT;
`ifdef CPU_CTRL_TRAP_EN
            ST_ERR:       w_next = ST_ERR;
`endif
            default:      w_next = ST_WAIT;
        endcase
    end

    cpu_ctrl_outdec u_outdec (
        .i_state (r_state),
        .i_instr (r_instr),
        .o_ctrl  (w_ctrl)
    );

    assign w     = w_ctrl.w;
    assign err   = w_ctrl.err;
    assign nsel  = w_ctrl.nsel;
    assign loada = w_ctrl.loada;
    assign loadb = w_ctrl.loadb;
    assign loadc = w_ctrl.loadc;
    assign loads = w_ctrl.loads;
    assign asel  = w_ctrl.asel;
    assign bsel  = w_ctrl.bsel;
    assign vsel  = w_ctrl.vsel;
    assign write = w_ctrl.write;

endmodule
